// File: rtl/addsub_accumulator_4bit.sv
// Sequential wrapper around a 4-bit combinational adder-subtractor.
// Accepts LOAD/ADD/SUB/CLR requests and returns accumulator results.
module addsub_accumulator_4bit #(
    parameter logic [3:0] ACC_INIT = 4'h0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_op,
    input  logic [3:0] in_data,
    output logic [3:0] as_a,
    output logic [3:0] as_b,
    output logic       as_cin,
    input  logic [3:0] as_sum,
    input  logic       as_carry,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_acc,
    output logic       out_carry,
    output logic       out_zero,
    output logic       out_neg,
    output logic       out_ovf,
    output logic       ovf_sticky
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    state_t     state_q, state_d;
    logic [3:0] acc_q, acc_d;
    logic [3:0] opnd_q, opnd_d;
    logic       sub_q, sub_d;
    logic       carry_q, carry_d;
    logic       ovf_q, ovf_d;
    logic       sticky_q, sticky_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;

    logic       a3, b3, s3;
    logic       exec_ovf;

    // Signed overflow of the op being executed, from operand sign bits.
    always_comb begin
        a3 = acc_q[3];
        b3 = opnd_q[3];
        s3 = as_sum[3];
        if (sub_q) begin
            exec_ovf = (a3 != b3) && (s3 != a3);
        end else begin
            exec_ovf = (a3 == b3) && (s3 != a3);
        end
    end

    // Next-state and datapath update for the IDLE/EXEC/RESP controller.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        sub_d    = sub_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        sticky_d = sticky_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    unique case (in_op)
                        OP_LOAD: begin
                            acc_d   = in_data;
                            carry_d = 1'b0;
                            ovf_d   = 1'b0;
                            state_d = RESP;
                        end
                        OP_ADD, OP_SUB: begin
                            opnd_d  = in_data;
                            sub_d   = (in_op == OP_SUB);
                            state_d = EXEC;
                        end
                        OP_CLR: begin
                            acc_d    = ACC_INIT;
                            carry_d  = 1'b0;
                            ovf_d    = 1'b0;
                            sticky_d = 1'b0;
                            state_d  = RESP;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            EXEC: begin
                acc_d    = as_sum;
                carry_d  = as_carry;
                ovf_d    = exec_ovf;
                sticky_d = sticky_q | exec_ovf;
                state_d  = RESP;
            end
            RESP: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == RESP);
    end

    // Single state register; handshake outputs are registered alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= ACC_INIT;
            opnd_q      <= 4'h0;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            sticky_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            sub_q       <= sub_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            sticky_q    <= sticky_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;

    assign as_a       = acc_q;
    assign as_b       = opnd_q;
    assign as_cin     = sub_q;

    assign out_acc    = acc_q;
    assign out_carry  = carry_q;
    assign out_zero   = (acc_q == 4'h0);
    assign out_neg    = acc_q[3];
    assign out_ovf    = ovf_q;
    assign ovf_sticky = sticky_q;

    a_hs_excl: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(in_ready_q && out_valid_q)
    );

    a_bp_hold: assert property (
        @(posedge clk) disable iff (!rst_n)
        (out_valid_q && !out_ready) |=>
            (out_valid_q && $stable(acc_q) && $stable(ovf_q))
    );

endmodule

// File: tb/tb_addsub_accumulator_4bit.sv
// Bench for addsub_accumulator_4bit with a behavioural adder-subtractor.
// Expected results are queued at request time and popped on out_valid.
module tb_addsub_accumulator_4bit;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;
    localparam logic [3:0] INIT    = 4'h0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [3:0] in_data;
    logic [3:0] as_a, as_b, as_sum;
    logic       as_cin, as_carry;
    logic       out_valid, out_ready;
    logic [3:0] out_acc;
    logic       out_carry, out_zero, out_neg, out_ovf, ovf_sticky;

    typedef struct packed {
        logic [3:0] acc;
        logic       carry;
        logic       zero;
        logic       neg;
        logic       ovf;
        logic       sticky;
    } res_t;

    res_t       q[$];
    logic [3:0] m_acc;
    logic       m_sticky;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    // External adder-subtractor: a + (cin ? ~b : b) + cin.
    logic [4:0] full;
    assign full = {1'b0, as_a} + {1'b0, (as_cin ? ~as_b : as_b)}
                + {4'b0, as_cin};
    assign as_sum   = full[3:0];
    assign as_carry = full[4];

    addsub_accumulator_4bit dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_data(in_data),
        .as_a(as_a), .as_b(as_b), .as_cin(as_cin),
        .as_sum(as_sum), .as_carry(as_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_carry(out_carry),
        .out_zero(out_zero), .out_neg(out_neg),
        .out_ovf(out_ovf), .ovf_sticky(ovf_sticky)
    );

    function automatic res_t act();
        res_t r;
        r = {out_acc, out_carry, out_zero, out_neg, out_ovf, ovf_sticky};
        return r;
    endfunction

    function automatic int sval(input logic [3:0] v);
        return (v >= 4'd8) ? int'(v) - 16 : int'(v);
    endfunction

    task automatic model(input logic [1:0] op, input logic [3:0] d,
                         output res_t e);
        logic [3:0] s;
        logic       c, o;
        int         r;
        s = m_acc; c = 1'b0; o = 1'b0;
        case (op)
            OP_LOAD: s = d;
            OP_ADD: begin
                s = m_acc + d;
                c = (int'(m_acc) + int'(d)) > 15;
                r = sval(m_acc) + sval(d);
                o = (r > 7) || (r < -8);
            end
            OP_SUB: begin
                s = m_acc - d;
                c = (m_acc >= d);
                r = sval(m_acc) - sval(d);
                o = (r > 7) || (r < -8);
            end
            default: begin
                s = INIT;
                m_sticky = 1'b0;
            end
        endcase
        m_sticky = m_sticky | o;
        m_acc = s;
        e = {s, c, (s == 4'h0), s[3], o, m_sticky};
    endtask

    task automatic do_op(input logic [1:0] op, input logic [3:0] d,
                         input int hold);
        res_t e, a;
        int   n, lat, exp_lat;
        model(op, d, e);
        q.push_back(e);
        exp_lat = (op == OP_ADD || op == OP_SUB) ? 2 : 1;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_data = d;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL accept op=%0d: in_ready=%b required 1",
                     op, in_ready);
            in_valid = 1'b0;
            e = q.pop_front();
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1 && exp_lat == 2) begin
                n_cmp++;
                if ({as_cin, as_b} !== {(op == OP_SUB), d}) begin
                    n_bad++;
                    $display("FAIL exec_drive: cin/b=%b/%h required %b/%h",
                             as_cin, as_b, (op == OP_SUB), d);
                end
            end
        end while (!out_valid && lat < 8);
        n_cmp++;
        if (lat !== exp_lat) begin
            n_bad++;
            $display("FAIL latency op=%0d: %0d edges required %0d",
                     op, lat, exp_lat);
        end
        e = q.pop_front();
        a = act();
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL result op=%0d d=%h: got %b required %b",
                     op, d, a, e);
        end
        if (hold > 0) begin
            in_valid = 1'b1; in_op = OP_LOAD; in_data = 4'h3;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, in_ready, act()} !== {2'b10, e}) begin
                n_bad++;
                $display("FAIL hold%0d: v/r/res=%b%b/%b required 10/%b",
                         i, out_valid, in_ready, act(), e);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL handoff: valid/ready=%b%b required 01",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_op = OP_LOAD;
        in_data = 4'h0; out_ready = 1'b0;
        m_acc = INIT; m_sticky = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready, out_acc, out_carry, out_ovf, ovf_sticky,
             as_a, as_b, as_cin} !== {2'b01, INIT, 3'b000, INIT, 5'b0}) begin
            n_bad++;
            $display("FAIL reset_state: v=%b r=%b acc=%h b=%h cin=%b",
                     out_valid, in_ready, out_acc, as_b, as_cin);
        end
        rst_n = 1'b1;
        do_op(OP_LOAD, 4'h7, 0);
        do_op(OP_ADD, 4'h1, 0);
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_ADD; in_data = 4'h2;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, out_acc, ovf_sticky} !==
            {2'b01, INIT, 1'b0}) begin
            n_bad++;
            $display("FAIL async_reset: v=%b r=%b acc=%h st=%b req 0 1 %h 0",
                     out_valid, in_ready, out_acc, ovf_sticky, INIT);
        end
        m_acc = INIT; m_sticky = 1'b0;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        do_op(OP_LOAD, 4'h4, 0);
    endtask

    task automatic test_add_ovf();
        do_op(OP_LOAD, 4'h5, 0);
        do_op(OP_ADD, 4'h3, 0);
    endtask

    task automatic test_sub_borrow();
        do_op(OP_LOAD, 4'h3, 0);
        do_op(OP_SUB, 4'h5, 0);
    endtask

    task automatic test_sub_zero();
        do_op(OP_LOAD, 4'h7, 0);
        do_op(OP_SUB, 4'h7, 0);
    endtask

    task automatic test_wrap();
        do_op(OP_LOAD, 4'hF, 0);
        do_op(OP_ADD, 4'h1, 0);
        do_op(OP_SUB, 4'h1, 0);
    endtask

    task automatic test_backpressure();
        do_op(OP_LOAD, 4'h1, 0);
        do_op(OP_ADD, 4'h7, 5);
        @(negedge clk);
        n_cmp++;
        if ({out_acc, out_valid} !== {4'h8, 1'b0}) begin
            n_bad++;
            $display("FAIL ignored_req: acc=%h v=%b required 8 0",
                     out_acc, out_valid);
        end
        do_op(OP_CLR, 4'h9, 0);
    endtask

    task automatic test_back_to_back();
        do_op(OP_SUB, 4'h8, 0);
        do_op(OP_ADD, 4'h9, 0);
        do_op(OP_LOAD, 4'hA, 0);
        do_op(OP_ADD, 4'hB, 0);
    endtask

    initial begin
        test_reset();
        test_add_ovf();
        test_sub_borrow();
        test_sub_zero();
        test_wrap();
        test_backpressure();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
